// File: rtl/pulse_period_checker_if.sv
// Pulse stream in, lock/error status out, for pulse_period_checker.
interface pulse_period_checker_if #(
  parameter int ERR_W = 8
);
  logic             pulse_in;
  logic             clear_err;
  logic             locked;
  logic             period_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output pulse_in, clear_err,
    input  locked, period_err, err_count
  );

  modport slave (
    input  pulse_in, clear_err,
    output locked, period_err, err_count
  );
endinterface

// File: rtl/pulse_period_checker.sv
// Checks that pulse_in repeats every N clocks; declares lock after LOCK_CNT good intervals.
// Outputs are registered, so status changes show one cycle after the deciding edge.
module pulse_period_checker #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input logic                   clk,
  input logic                   reset,
  pulse_period_checker_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(N - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GOOD_FULL = GW'(LOCK_CNT);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    good;
  logic             locked_q;
  logic             period_err_q;
  logic [ERR_W-1:0] err_count_q;

  logic on_time;
  logic early;
  logic missing;
  logic lock_err;

  // cnt saturates at CNT_MAX, so "not at max" means the pulse came early
  assign on_time  = bus.pulse_in && (cnt == CNT_MAX);
  assign early    = bus.pulse_in && (cnt != CNT_MAX);
  assign missing  = !bus.pulse_in && (cnt == CNT_MAX);
  assign lock_err = (state == LOCKED) && (early || missing);

  assign bus.locked     = locked_q;
  assign bus.period_err = period_err_q;
  assign bus.err_count  = err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      cnt          <= '0;
      good         <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      if (bus.pulse_in)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      period_err_q <= lock_err;

      // clear wins over a coincident error; period_err still reports it
      if (bus.clear_err)
        err_count_q <= '0;
      else if (lock_err && (err_count_q != '1))
        err_count_q <= err_count_q + 1'b1;

      case (state)
        HUNT: begin
          if (bus.pulse_in) begin
            state <= TRACK;
            good  <= '0;
          end
        end
        TRACK: begin
          if (on_time) begin
            if (good == GOOD_LAST) begin
              state    <= LOCKED;
              good     <= GOOD_FULL;
              locked_q <= 1'b1;
            end else begin
              good <= good + 1'b1;
            end
          end else if (early) begin
            good <= '0;
          end else if (missing) begin
            state <= HUNT;
            good  <= '0;
          end
        end
        LOCKED: begin
          if (early) begin
            state    <= TRACK;
            good     <= '0;
            locked_q <= 1'b0;
          end else if (missing) begin
            state    <= HUNT;
            good     <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= HUNT;
          good     <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench: N=3, LOCK_CNT=4, with an 8-bit and a 2-bit err_count instance on shared stimulus.
module tb_pulse_period_checker;
  logic clk = 1'b0;
  logic reset;
  logic pulse;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pulse_period_checker_if #(.ERR_W(8)) bus_a ();
  pulse_period_checker_if #(.ERR_W(2)) bus_b ();

  assign bus_a.pulse_in  = pulse;
  assign bus_a.clear_err = clr;
  assign bus_b.pulse_in  = pulse;
  assign bus_b.clear_err = clr;

  pulse_period_checker #(.N(3), .LOCK_CNT(4), .ERR_W(8)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  pulse_period_checker #(.N(3), .LOCK_CNT(4), .ERR_W(2)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  task automatic tick(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
  endtask

  // from TRACK with cnt=0 (just after a pulse): four on-time intervals
  task automatic relock();
    repeat (4) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr   = 1'b0;
    tick(1'b1);
    tick(1'b0);
    checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus_a.locked); end
    checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL reset_period_err: got %b want 0", bus_a.period_err); end
    checks++; if (bus_a.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", bus_a.err_count); end
    checks++; if (bus_b.err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count_w2: got %0d want 0", bus_b.err_count); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    for (int i = 0; i <= 12; i++) begin
      tick(i % 3 == 0);
      checks++; if (bus_a.locked !== (i == 12)) begin errors++; $display("FAIL lock_step%0d: locked got %b want %b", i, bus_a.locked, i == 12); end
      checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL lock_perr_step%0d: got %b want 0", i, bus_a.period_err); end
    end
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    checks++; if (bus_a.locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b want 1", bus_a.locked); end
    checks++; if (bus_a.err_count !== 8'd0) begin errors++; $display("FAIL lock_err_count: got %0d want 0", bus_a.err_count); end
  endtask

  task automatic test_early();
    tick(1'b0);
    tick(1'b1);
    checks++; if (bus_a.period_err !== 1'b1) begin errors++; $display("FAIL early_perr: got %b want 1", bus_a.period_err); end
    checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL early_locked: got %b want 0", bus_a.locked); end
    checks++; if (bus_a.err_count !== 8'd1) begin errors++; $display("FAIL early_err_count: got %0d want 1", bus_a.err_count); end
    tick(1'b0);
    checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL early_perr_width: got %b want 0", bus_a.period_err); end
    tick(1'b0);
    tick(1'b1);
    for (int k = 2; k <= 4; k++) begin
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL early_relock_k%0d: got %b want 0", k, bus_a.locked); end
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
    end
    checks++; if (bus_a.locked !== 1'b1) begin errors++; $display("FAIL early_relock: got %b want 1", bus_a.locked); end
  endtask

  task automatic test_missing();
    tick(1'b0);
    tick(1'b0);
    checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL miss_before: got %b want 0", bus_a.period_err); end
    tick(1'b0);
    checks++; if (bus_a.period_err !== 1'b1) begin errors++; $display("FAIL miss_perr: got %b want 1", bus_a.period_err); end
    checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL miss_locked: got %b want 0", bus_a.locked); end
    checks++; if (bus_a.err_count !== 8'd2) begin errors++; $display("FAIL miss_err_count: got %0d want 2", bus_a.err_count); end
    tick(1'b0);
    checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL miss_perr_width: got %b want 0", bus_a.period_err); end
    tick(1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      checks++; if (bus_a.locked !== (k == 4)) begin errors++; $display("FAIL miss_relock_k%0d: got %b want %b", k, bus_a.locked, k == 4); end
    end
  endtask

  task automatic test_saturation();
    repeat (3) begin
      tick(1'b0);
      tick(1'b1);
      relock();
    end
    checks++; if (bus_a.err_count !== 8'd5) begin errors++; $display("FAIL sat_count8: got %0d want 5", bus_a.err_count); end
    checks++; if (bus_b.err_count !== 2'd3) begin errors++; $display("FAIL sat_count2: got %0d want 3", bus_b.err_count); end
    checks++; if (bus_b.locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", bus_b.locked); end
    tick(1'b0);
    clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    checks++; if (bus_b.err_count !== 2'd0) begin errors++; $display("FAIL clr_count2: got %0d want 0", bus_b.err_count); end
    checks++; if (bus_a.err_count !== 8'd0) begin errors++; $display("FAIL clr_count8: got %0d want 0", bus_a.err_count); end
    checks++; if (bus_b.period_err !== 1'b1) begin errors++; $display("FAIL clr_perr: got %b want 1", bus_b.period_err); end
    relock();
  endtask

  task automatic test_reset_locked();
    repeat (5) begin
      tick(1'b0);
      tick(1'b1);
      relock();
    end
    checks++; if (bus_a.err_count !== 8'd5) begin errors++; $display("FAIL rl_pre_count: got %0d want 5", bus_a.err_count); end
    checks++; if (bus_a.locked !== 1'b1) begin errors++; $display("FAIL rl_pre_locked: got %b want 1", bus_a.locked); end
    // the pulse in the reset cycle would be an early (error) pulse if not ignored
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL rl_locked: got %b want 0", bus_a.locked); end
    checks++; if (bus_a.err_count !== 8'd0) begin errors++; $display("FAIL rl_err_count: got %0d want 0", bus_a.err_count); end
    checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL rl_perr: got %b want 0", bus_a.period_err); end
    for (int i = 0; i <= 14; i++) begin
      tick(i % 3 == 2);
      checks++; if (bus_a.locked !== (i == 14)) begin errors++; $display("FAIL rl_relock_step%0d: got %b want %b", i, bus_a.locked, i == 14); end
    end
  endtask

  task automatic test_continuous();
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      checks++; if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL cont_locked%0d: got %b want 0", i, bus_a.locked); end
      checks++; if (bus_a.period_err !== 1'b0) begin errors++; $display("FAIL cont_perr%0d: got %b want 0", i, bus_a.period_err); end
      checks++; if (bus_a.err_count !== 8'd0) begin errors++; $display("FAIL cont_count%0d: got %0d want 0", i, bus_a.err_count); end
    end
  endtask

  initial begin
    pulse = 1'b0;
    clr   = 1'b0;
    reset = 1'b1;
    test_reset();
    test_lock();
    test_early();
    test_missing();
    test_saturation();
    test_reset_locked();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_period_checker.md
PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

Interface
REQ-001 Parameter N, default 3: expected pulse period in clk cycles; legal range N >= 2.
REQ-002 Parameter LOCK_CNT, default 4: consecutive correct intervals required to declare lock; legal range >= 1.
REQ-003 Parameter ERR_W, default 8: width of err_count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pulse_in  input  1  monitored pulse stream from a divide-by-N generator; sampled on every rising clk edge.
REQ-007 clear_err  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while the checker is in LOCKED.
REQ-009 period_err  output  1  one-cycle error strobe, registered.
REQ-010 err_count  output  ERR_W  saturating count of period errors detected while locked.

Function
REQ-011 The block SHALL keep an interval counter cnt of width clog2(N): cnt loads 0 in any cycle where pulse_in=1 is sampled, else increments, saturating at N-1.
REQ-012 A sampled pulse SHALL be "on time" iff cnt==N-1 at that edge, and "early" iff cnt<N-1.
REQ-013 A "missing" pulse SHALL be detected at an edge where cnt==N-1 and pulse_in=0.
REQ-014 The FSM SHALL have three states: HUNT, TRACK and LOCKED, plus a good-interval counter good (0..LOCK_CNT).
REQ-015 HUNT: a pulse -> TRACK, with good=0 and cnt=0; no pulse -> remain in HUNT.
REQ-016 TRACK, on-time pulse: good SHALL increment; when the incremented value equals LOCK_CNT the FSM SHALL move to LOCKED.
REQ-017 TRACK, early pulse: good SHALL be set to 0 and the FSM SHALL remain in TRACK; no error is raised.
REQ-018 TRACK, missing pulse: the FSM SHALL move to HUNT with good=0; no error is raised.
REQ-019 LOCKED, on-time pulse: the FSM SHALL remain in LOCKED.
REQ-020 LOCKED, early pulse: the FSM SHALL move to TRACK with good=0, and SHALL pulse period_err and increment err_count.
REQ-021 LOCKED, missing pulse: the FSM SHALL move to HUNT, and SHALL pulse period_err and increment err_count.
REQ-022 period_err SHALL be high for exactly the one cycle following the detecting edge; it SHALL be asserted only for errors detected in LOCKED.
REQ-023 locked SHALL be a Moore output, high in the cycle after the transition into LOCKED, low in the cycle after the transition out.
REQ-024 err_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-025 clear_err SHALL set err_count to 0 on the next edge; when clear_err and an error occur on the same edge, clear wins (err_count=0) and period_err still pulses.
REQ-026 pulse_in held continuously high SHALL produce early pulses every cycle: the block never locks, and never flags an error from TRACK.

Reset
REQ-027 When reset=1 at an edge: state=HUNT, cnt=0, good=0, locked=0, period_err=0, err_count=0; pulse_in is ignored in that cycle.
REQ-028 Reset SHALL take priority over every other event, including mid-operation in LOCKED.
REQ-029 After reset deassertion, the first sampled pulse SHALL be treated as a HUNT pulse.

Verification (N=3, LOCK_CNT=4, ERR_W=8 unless stated)
REQ-030 Pulses at cycles 0, 3, 6, 9, 12 after reset release -> locked=1 from cycle 13 onward; period_err never asserted; err_count=0.
REQ-031 Locked, then next pulse 2 cycles after the previous one -> period_err high for 1 cycle, err_count=1, locked=0 the next cycle; locked=1 again after 4 further on-time intervals.
REQ-032 Locked, one pulse omitted -> period_err at the edge after the expected-pulse cycle, err_count=1, FSM in HUNT, locked=0; relock requires 1 HUNT pulse plus 4 on-time intervals.
REQ-033 ERR_W=2, 5 locked-state errors -> err_count=3 (saturated); clear_err asserted on the same edge as a 6th error -> err_count=0 and period_err=1.
REQ-034 Reset asserted for 1 cycle while locked with err_count=5 -> next cycle locked=0, err_count=0, period_err=0; a pulse in the reset cycle is ignored.
REQ-035 pulse_in held high for 20 cycles -> locked stays 0, period_err stays 0, err_count stays 0.
